ac97_frame_tx: RTL and testbench
================================

// Module: ac97_frame_tx
// PURPOSE
//  AC97 link transmitter: serializes 256-bit output frames on SDATA_OUT/SYNC, driven by the codec's BITCLK.
//  Carries the sound_controller SO2/SO1 mix as PCM left/right (slots 3/4) and an optional codec register write (slots 1/2).
//  Issues the once-per-frame sample strobe (48 kHz) that paces sound_controller and the channels.
//  Single clock domain (I_CLK); BITCLK is sampled as data and edge-detected.
// PARAMETERS
//  SYNC_STAGES  2   flops synchronizing I_BITCLK into I_CLK (>=2)
//  SAMPLE_W     20  PCM sample width; MSB-aligned in 20-bit slot, LSBs zero-padded
// PORTS
//  I_CLK        in   1   system clock, >= 4x BITCLK (12.288 MHz)
//  I_RESET      in   1   synchronous, active-high reset
//  I_BITCLK     in   1   raw AC97 bit clock from codec
//  I_SO1        in   20  right sample (sound_controller O_SO1)
//  I_SO2        in   20  left sample (sound_controller O_SO2)
//  O_STROBE     out  1   1-cycle pulse: samples latched, producer may advance
//  I_CMD_VALID  in   1   codec register write request
//  I_CMD_ADDR   in   7   codec register address
//  I_CMD_DATA   in   16  codec register data
//  O_CMD_READY  out  1   command holding register free
//  O_SYNC       out  1   AC97 SYNC
//  O_SDATA_OUT  out  1   AC97 serial data out, MSB first
// BEHAVIOUR
//  Interface: one clock I_CLK; reset I_RESET is synchronous and active-high.
//  Reset (and reset asserted mid-frame): next cycle O_SYNC=0, O_SDATA_OUT=0, O_STROBE=0, O_CMD_READY=1,
//   bit_cnt=0, pending/latched command dropped, sample regs=0, sync chain cleared.
//  Edge detect: bclk_rise = sync[last] & ~prev; all frame state advances only on bclk_rise cycles.
//  Outputs are registered, update the cycle after bclk_rise (raw-edge latency SYNC_STAGES+1 I_CLK).
//  bit_cnt 0..255, increments per bclk_rise, wraps 255->0; bit b is driven while bit_cnt==b.
//  Frame start (bclk_rise with bit_cnt==0): latch I_SO2->left, I_SO1->right; O_STROBE=1 for exactly that one
//   following cycle; if cmd_pending, copy command into slot regs and set cmd_in_frame, else clear it.
//  O_SYNC=1 for bit_cnt 0..15 (slot 0), 0 for 16..255.
//  Slot 0 tag (bits 0..15 = tag[15:0] MSB first): [15]=1 frame valid, [14]=cmd_in_frame, [13]=cmd_in_frame,
//   [12]=1, [11]=1 (slots 3,4 valid), [10:0]=0.
//  Slot n (1..12) occupies bit_cnt 16+20*(n-1) .. 35+20*(n-1), 20 bits MSB first.
//  Slot 1 (16..35): {1'b0 write, ADDR[6:0], 12'b0} if cmd_in_frame else 20'b0.
//  Slot 2 (36..55): {DATA[15:0], 4'b0} if cmd_in_frame else 20'b0.
//  Slot 3 (56..75): left; slot 4 (76..95): right; samples narrower than 20 zero-padded in LSBs.
//  Slots 5..12 (96..255): O_SDATA_OUT=0.
//  Command handshake: accept on I_CMD_VALID & O_CMD_READY; O_CMD_READY=0 from next cycle, cmd_pending=1.
//   Handshake in the same cycle as a frame-start latch is NOT taken by that frame; it goes in the next.
//   cmd_pending clears at the frame start that consumes it; O_CMD_READY returns 1 the cycle after bclk_rise
//   with bit_cnt==55 of that frame. At most one command per frame.
//  I_SO1/I_SO2 are sampled only at frame start; changes mid-frame never alter the current frame.
//  I_BITCLK stopped: state holds, O_STROBE stays 0, outputs hold last value.
// TESTING
//  Reset then 256 BITCLK edges, I_SO2=20'hABCDE, I_SO1=20'h12345 -> SYNC high 16 bits; tag 16'h9800;
//   slot3 bits = ABCDE, slot4 = 12345 MSB first; exactly one O_STROBE per 256 edges.
//  Command ADDR=7'h02, DATA=16'h8000 -> next frame tag 16'hF800, slot1=20'h02000, slot2=20'h80000;
//   O_CMD_READY low until after bit 55, then high; following frame tag back to 16'h9800.
//  I_CMD_VALID on exact frame-start cycle -> slots 1/2 zero in that frame, command in the next one.
//  Change I_SO1 at bit_cnt==60 -> slot 4 carries old value; new value appears next frame.
//  I_RESET asserted at bit_cnt==70 with command pending -> outputs 0 next cycle; after release first frame
//   starts at bit 0, tag 16'h9800, O_CMD_READY=1.
//  BITCLK at I_CLK/4 and I_CLK/9, with I_BITCLK jitter +/-1 I_CLK -> no skipped/duplicated bits, wrap 255->0 clean.

Source files
------------

// File: rtl/ac97_frame_tx.sv
// AC97 link transmitter: serializes 256-bit frames on SDATA_OUT/SYNC from a
// BITCLK that is synchronized into I_CLK and edge-detected. Slot 0 tag, an
// optional codec register write in slots 1/2 and PCM left/right in slots 3/4.
module ac97_frame_tx #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_W    = 20
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                I_BITCLK,
    input  logic [SAMPLE_W-1:0] I_SO1,
    input  logic [SAMPLE_W-1:0] I_SO2,
    output logic                O_STROBE,
    input  logic                I_CMD_VALID,
    input  logic [6:0]          I_CMD_ADDR,
    input  logic [15:0]         I_CMD_DATA,
    output logic                O_CMD_READY,
    output logic                O_SYNC,
    output logic                O_SDATA_OUT
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   bclk_prev_q;
    logic                   bclk_rise;

    logic [7:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] left_q, left_d;
    logic [SAMPLE_W-1:0] right_q, right_d;
    logic                pend_q, pend_d;
    logic                cif_q, cif_d;
    logic [6:0]          hold_addr_q, hold_addr_d;
    logic [15:0]         hold_data_q, hold_data_d;
    logic [6:0]          slot_addr_q, slot_addr_d;
    logic [15:0]         slot_data_q, slot_data_d;
    logic                sync_o_q, sync_o_d;
    logic                sdata_q, sdata_d;
    logic                strobe_q, strobe_d;
    logic                ready_q, ready_d;

    // Place a sample MSB-first in the 20-bit slot, zero-padding the LSBs.
    function automatic logic [19:0] msb_align(input logic [SAMPLE_W-1:0] s);
        return 20'(s) << (20 - SAMPLE_W);
    endfunction

    // Serial bit for frame position b; slots 5..12 and anything past 95 are zero.
    function automatic logic frame_bit(
        input logic [7:0]  b,
        input logic        cif,
        input logic [6:0]  addr,
        input logic [15:0] data,
        input logic [19:0] l20,
        input logic [19:0] r20
    );
        logic [15:0] tag;
        logic [19:0] word;
        logic [7:0]  off;
        logic        res;
        tag  = {1'b1, cif, cif, 1'b1, 1'b1, 11'd0};
        word = '0;
        off  = '0;
        res  = 1'b0;
        if (b < 8'd16) begin
            res = tag[4'(8'd15 - b)];
        end else begin
            if (b < 8'd36) begin
                word = cif ? {1'b0, addr, 12'd0} : 20'd0;
                off  = b - 8'd16;
            end else if (b < 8'd56) begin
                word = cif ? {data, 4'd0} : 20'd0;
                off  = b - 8'd36;
            end else if (b < 8'd76) begin
                word = l20;
                off  = b - 8'd56;
            end else if (b < 8'd96) begin
                word = r20;
                off  = b - 8'd76;
            end
            res = word[5'(8'd19 - off)];
        end
        return res;
    endfunction

    assign bclk_rise = sync_q[SYNC_STAGES-1] & ~bclk_prev_q;

    // Frame sequencing, sample/command latching and next serial outputs.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        left_d      = left_q;
        right_d     = right_q;
        pend_d      = pend_q;
        cif_d       = cif_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        slot_addr_d = slot_addr_q;
        slot_data_d = slot_data_q;
        sync_o_d    = sync_o_q;
        sdata_d     = sdata_q;
        strobe_d    = 1'b0;
        ready_d     = ready_q;

        if (bclk_rise) begin
            bit_cnt_d = bit_cnt_q + 8'd1;
            if (bit_cnt_q == 8'd0) begin
                left_d   = I_SO2;
                right_d  = I_SO1;
                strobe_d = 1'b1;
                cif_d    = pend_q;
                if (pend_q) begin
                    slot_addr_d = hold_addr_q;
                    slot_data_d = hold_data_q;
                    pend_d      = 1'b0;
                end
            end
            // Slots 1/2 are fully shifted out after bit 55, so the holder may refill.
            if (cif_q && bit_cnt_q == 8'd55) begin
                ready_d = 1'b1;
            end
            sync_o_d = (bit_cnt_q < 8'd16);
            sdata_d  = frame_bit(bit_cnt_q, cif_d, slot_addr_d, slot_data_d,
                                 msb_align(left_d), msb_align(right_d));
        end

        // A handshake coinciding with a frame start sees pend_q=0 there, so it
        // is carried by the following frame.
        if (I_CMD_VALID && ready_q) begin
            hold_addr_d = I_CMD_ADDR;
            hold_data_d = I_CMD_DATA;
            pend_d      = 1'b1;
            ready_d     = 1'b0;
        end
    end

    // Control, synchronizer and output registers with synchronous reset.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
            bit_cnt_q   <= 8'd0;
            left_q      <= '0;
            right_q     <= '0;
            pend_q      <= 1'b0;
            cif_q       <= 1'b0;
            sync_o_q    <= 1'b0;
            sdata_q     <= 1'b0;
            strobe_q    <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], I_BITCLK};
            bclk_prev_q <= sync_q[SYNC_STAGES-1];
            bit_cnt_q   <= bit_cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            pend_q      <= pend_d;
            cif_q       <= cif_d;
            sync_o_q    <= sync_o_d;
            sdata_q     <= sdata_d;
            strobe_q    <= strobe_d;
            ready_q     <= ready_d;
        end
    end

    // Command payload registers; only meaningful while pend_q/cif_q qualify them.
    always_ff @(posedge I_CLK) begin
        hold_addr_q <= hold_addr_d;
        hold_data_q <= hold_data_d;
        slot_addr_q <= slot_addr_d;
        slot_data_q <= slot_data_d;
    end

    assign O_STROBE    = strobe_q;
    assign O_CMD_READY = ready_q;
    assign O_SYNC      = sync_o_q;
    assign O_SDATA_OUT = sdata_q;

endmodule

// File: tb/tb_ac97_frame_tx.sv
// Testbench for ac97_frame_tx: drives a jittered BITCLK, captures each frame
// bit by bit and compares against frames assembled from slot contents.
module tb_ac97_frame_tx;

    logic        I_CLK = 1'b0;
    logic        I_RESET;
    logic        I_BITCLK;
    logic [19:0] I_SO1;
    logic [19:0] I_SO2;
    logic        O_STROBE;
    logic        I_CMD_VALID;
    logic [6:0]  I_CMD_ADDR;
    logic [15:0] I_CMD_DATA;
    logic        O_CMD_READY;
    logic        O_SYNC;
    logic        O_SDATA_OUT;

    always #5 I_CLK = ~I_CLK;

    ac97_frame_tx #(.SYNC_STAGES(2), .SAMPLE_W(20)) dut (
        .I_CLK       (I_CLK),
        .I_RESET     (I_RESET),
        .I_BITCLK    (I_BITCLK),
        .I_SO1       (I_SO1),
        .I_SO2       (I_SO2),
        .O_STROBE    (O_STROBE),
        .I_CMD_VALID (I_CMD_VALID),
        .I_CMD_ADDR  (I_CMD_ADDR),
        .I_CMD_DATA  (I_CMD_DATA),
        .O_CMD_READY (O_CMD_READY),
        .O_SYNC      (O_SYNC),
        .O_SDATA_OUT (O_SDATA_OUT)
    );

    localparam logic [255:0] SYNC_EXP = {16'hFFFF, 240'd0};
    localparam logic [255:0] STB_EXP  = {1'b1, 255'd0};

    int n_total = 0;
    int n_bad   = 0;
    int stb_count = 0;

    // captured frame: bit b of the frame lives at index 255-b
    logic [255:0] cap_sd, cap_sy, cap_rdy, cap_stb;

    // BITCLK shape and per-bit hooks
    int          hbase = 2;
    int          lbase = 2;
    bit          jit   = 1'b1;
    int          hk_cmd_bit = -1;
    logic [6:0]  hk_addr = '0;
    logic [15:0] hk_data = '0;
    int          hk_so1_bit = -1;
    logic [19:0] hk_so1_val = '0;
    bit          hk_fs_cmd = 1'b0;

    // Reference frame assembled from the slot layout.
    function automatic logic [255:0] model_frame(input bit cif, input logic [6:0] a,
                                                 input logic [15:0] d,
                                                 input logic [19:0] l, input logic [19:0] r);
        logic [15:0] tag;
        logic [19:0] s1, s2;
        tag = {1'b1, cif, cif, 1'b1, 1'b1, 11'd0};
        s1  = cif ? {1'b0, a, 12'd0} : 20'd0;
        s2  = cif ? {d, 4'd0} : 20'd0;
        return {tag, s1, s2, l, r, 160'd0};
    endfunction

    // Expected O_CMD_READY per bit: low inside the two given bit ranges.
    function automatic logic [255:0] rdy_exp(input int a0, input int a1, input int b0, input int b1);
        logic [255:0] v;
        v = '1;
        for (int b = 0; b < 256; b++)
            if ((b >= a0 && b <= a1) || (b >= b0 && b <= b1)) v[255-b] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(negedge I_CLK);
        if (O_STROBE === 1'b1) stb_count++;
    endtask

    // Drive one BITCLK period per bit and capture outputs at the end of it.
    task automatic run_bits(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            int b;
            int h;
            int l;
            int s0;
            b = first + i;
            if (b == hk_cmd_bit) begin
                I_CMD_ADDR  = hk_addr;
                I_CMD_DATA  = hk_data;
                I_CMD_VALID = 1'b1;
                tick();
                I_CMD_VALID = 1'b0;
            end
            if (b == hk_so1_bit) I_SO1 = hk_so1_val;
            h = hbase;
            l = lbase;
            if (jit) begin
                l = lbase + int'($urandom_range(0, 2)) - 1;
                if (hbase > 2) h = hbase + int'($urandom_range(0, 2)) - 1;
            end
            s0 = stb_count;
            I_BITCLK = 1'b1;
            for (int c = 1; c <= h + l; c++) begin
                tick();
                if (c == h) I_BITCLK = 1'b0;
                if (hk_fs_cmd && b == 0) begin
                    if (c == 2) begin
                        I_CMD_ADDR  = hk_addr;
                        I_CMD_DATA  = hk_data;
                        I_CMD_VALID = 1'b1;
                    end
                    if (c == 3) I_CMD_VALID = 1'b0;
                end
            end
            if (b == 0) hk_fs_cmd = 1'b0;
            cap_sd[255-b]  = O_SDATA_OUT;
            cap_sy[255-b]  = O_SYNC;
            cap_rdy[255-b] = O_CMD_READY;
            cap_stb[255-b] = (stb_count != s0);
        end
    endtask

    task automatic test_reset();
        I_RESET = 1'b1;
        I_BITCLK = 1'b0;
        repeat (3) tick();
        n_total++; if (O_SYNC !== 1'b0) begin n_bad++; $display("FAIL reset_sync: got %b want 0", O_SYNC); end
        n_total++; if (O_SDATA_OUT !== 1'b0) begin n_bad++; $display("FAIL reset_sdata: got %b want 0", O_SDATA_OUT); end
        n_total++; if (O_STROBE !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %b want 0", O_STROBE); end
        n_total++; if (O_CMD_READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", O_CMD_READY); end
        I_RESET = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_basic();
        logic [255:0] e;
        I_SO2 = 20'hABCDE;
        I_SO1 = 20'h12345;
        run_bits(0, 256);
        e = model_frame(1'b0, 7'd0, 16'd0, 20'hABCDE, 20'h12345);
        n_total++; if (cap_sd[255:240] !== 16'h9800) begin n_bad++; $display("FAIL basic_tag: got %h want 9800", cap_sd[255:240]); end
        n_total++; if (cap_sd[199:180] !== 20'hABCDE) begin n_bad++; $display("FAIL basic_slot3: got %h want abcde", cap_sd[199:180]); end
        n_total++; if (cap_sd[179:160] !== 20'h12345) begin n_bad++; $display("FAIL basic_slot4: got %h want 12345", cap_sd[179:160]); end
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL basic_frame: got %h want %h", cap_sd, e); end
        n_total++; if (cap_sy !== SYNC_EXP) begin n_bad++; $display("FAIL basic_sync: got %h want %h", cap_sy, SYNC_EXP); end
        n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL basic_strobe: got %h want %h", cap_stb, STB_EXP); end
        n_total++; if (cap_rdy !== '1) begin n_bad++; $display("FAIL basic_ready: got %h want all ones", cap_rdy); end
    endtask

    task automatic test_command();
        logic [255:0] e;
        logic [19:0]  l, r;
        // frame A: command accepted mid-frame, not carried here
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        hk_cmd_bit = 100; hk_addr = 7'h02; hk_data = 16'h8000;
        run_bits(0, 256);
        hk_cmd_bit = -1;
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL cmd_frameA: got %h want %h", cap_sd, e); end
        n_total++; if (cap_rdy !== rdy_exp(100, 255, -1, -1)) begin n_bad++; $display("FAIL cmd_readyA: got %h want %h", cap_rdy, rdy_exp(100, 255, -1, -1)); end
        // frame B: carries the command
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        run_bits(0, 256);
        e = model_frame(1'b1, 7'h02, 16'h8000, l, r);
        n_total++; if (cap_sd[255:240] !== 16'hF800) begin n_bad++; $display("FAIL cmd_tagB: got %h want f800", cap_sd[255:240]); end
        n_total++; if (cap_sd[239:220] !== 20'h02000) begin n_bad++; $display("FAIL cmd_slot1B: got %h want 02000", cap_sd[239:220]); end
        n_total++; if (cap_sd[219:200] !== 20'h80000) begin n_bad++; $display("FAIL cmd_slot2B: got %h want 80000", cap_sd[219:200]); end
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL cmd_frameB: got %h want %h", cap_sd, e); end
        n_total++; if (cap_rdy !== rdy_exp(0, 54, -1, -1)) begin n_bad++; $display("FAIL cmd_readyB: got %h want %h", cap_rdy, rdy_exp(0, 54, -1, -1)); end
        // frame C: back to no command
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        run_bits(0, 256);
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        n_total++; if (cap_sd[255:240] !== 16'h9800) begin n_bad++; $display("FAIL cmd_tagC: got %h want 9800", cap_sd[255:240]); end
        n_total++; if (cap_rdy !== '1) begin n_bad++; $display("FAIL cmd_readyC: got %h want all ones", cap_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] e, re;
        logic [19:0]  l, r;
        logic [6:0]   pa;
        logic [15:0]  pd;
        int           k;
        pa = '0; pd = '0;
        for (int i = 0; i < 4; i++) begin
            l = 20'($urandom()); r = 20'($urandom());
            I_SO2 = l; I_SO1 = r;
            k = -1;
            if (i < 3) begin
                k = int'($urandom_range(56, 255));
                hk_cmd_bit = k;
                hk_addr = 7'($urandom());
                hk_data = 16'($urandom());
            end
            run_bits(0, 256);
            hk_cmd_bit = -1;
            e  = model_frame(i > 0, pa, pd, l, r);
            re = rdy_exp((i > 0) ? 0 : -1, (i > 0) ? 54 : -1, k, (k >= 0) ? 255 : -1);
            n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL b2b_frame%0d: got %h want %h", i, cap_sd, e); end
            n_total++; if (cap_rdy !== re) begin n_bad++; $display("FAIL b2b_ready%0d: got %h want %h", i, cap_rdy, re); end
            n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL b2b_strobe%0d: got %h want %h", i, cap_stb, STB_EXP); end
            pa = hk_addr; pd = hk_data;
        end
    endtask

    task automatic test_frame_start_cmd();
        logic [255:0] e;
        logic [19:0]  l, r;
        logic [6:0]   a;
        logic [15:0]  d;
        a = 7'($urandom()); d = 16'($urandom());
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        hk_addr = a; hk_data = d; hk_fs_cmd = 1'b1;
        run_bits(0, 256);
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL fs_frameD: got %h want %h", cap_sd, e); end
        n_total++; if (cap_rdy !== rdy_exp(0, 255, -1, -1)) begin n_bad++; $display("FAIL fs_readyD: got %h want all zero", cap_rdy); end
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        run_bits(0, 256);
        e = model_frame(1'b1, a, d, l, r);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL fs_frameE: got %h want %h", cap_sd, e); end
        n_total++; if (cap_rdy !== rdy_exp(0, 54, -1, -1)) begin n_bad++; $display("FAIL fs_readyE: got %h want %h", cap_rdy, rdy_exp(0, 54, -1, -1)); end
    endtask

    task automatic test_so1_change();
        logic [255:0] e;
        logic [19:0]  l, r0, r1;
        l = 20'($urandom()); r0 = 20'($urandom()); r1 = ~r0;
        I_SO2 = l; I_SO1 = r0;
        hk_so1_bit = 60; hk_so1_val = r1;
        run_bits(0, 256);
        hk_so1_bit = -1;
        e = model_frame(1'b0, 7'd0, 16'd0, l, r0);
        n_total++; if (cap_sd[179:160] !== r0) begin n_bad++; $display("FAIL so1_old: got %h want %h", cap_sd[179:160], r0); end
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL so1_frameF: got %h want %h", cap_sd, e); end
        run_bits(0, 256);
        n_total++; if (cap_sd[179:160] !== r1) begin n_bad++; $display("FAIL so1_new: got %h want %h", cap_sd[179:160], r1); end
    endtask

    task automatic test_stopped();
        logic [255:0] e;
        logic [19:0]  l, r;
        int           s0;
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        run_bits(0, 5);
        s0 = stb_count;
        repeat (40) tick();
        n_total++; if (O_SYNC !== 1'b1) begin n_bad++; $display("FAIL stop_sync: got %b want 1", O_SYNC); end
        n_total++; if (O_SDATA_OUT !== e[251]) begin n_bad++; $display("FAIL stop_sdata: got %b want %b", O_SDATA_OUT, e[251]); end
        n_total++; if (stb_count !== s0) begin n_bad++; $display("FAIL stop_strobe: got %0d want %0d", stb_count, s0); end
        run_bits(5, 251);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL stop_frame: got %h want %h", cap_sd, e); end
        n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL stop_strobe_pos: got %h want %h", cap_stb, STB_EXP); end
    endtask

    task automatic test_div9();
        logic [255:0] e;
        logic [19:0]  l, r;
        int           k;
        hbase = 4; lbase = 5;
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        k = int'($urandom_range(1, 255));
        hk_cmd_bit = k; hk_addr = 7'($urandom()); hk_data = 16'($urandom());
        run_bits(0, 256);
        hk_cmd_bit = -1;
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL div9_frame0: got %h want %h", cap_sd, e); end
        n_total++; if (cap_sy !== SYNC_EXP) begin n_bad++; $display("FAIL div9_sync0: got %h want %h", cap_sy, SYNC_EXP); end
        n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL div9_strobe0: got %h want %h", cap_stb, STB_EXP); end
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        run_bits(0, 256);
        e = model_frame(1'b1, hk_addr, hk_data, l, r);
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL div9_frame1: got %h want %h", cap_sd, e); end
        n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL div9_strobe1: got %h want %h", cap_stb, STB_EXP); end
        hbase = 2; lbase = 2;
    endtask

    task automatic test_reset_mid();
        logic [255:0] e;
        logic [19:0]  l, r;
        l = 20'($urandom()) | 20'h00020;
        r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        hk_cmd_bit = 10; hk_addr = 7'($urandom()); hk_data = 16'($urandom());
        run_bits(0, 71);
        hk_cmd_bit = -1;
        n_total++; if (O_SDATA_OUT !== 1'b1) begin n_bad++; $display("FAIL rmid_bit70: got %b want 1", O_SDATA_OUT); end
        I_RESET = 1'b1;
        tick();
        n_total++; if (O_SYNC !== 1'b0) begin n_bad++; $display("FAIL rmid_sync: got %b want 0", O_SYNC); end
        n_total++; if (O_SDATA_OUT !== 1'b0) begin n_bad++; $display("FAIL rmid_sdata: got %b want 0", O_SDATA_OUT); end
        n_total++; if (O_STROBE !== 1'b0) begin n_bad++; $display("FAIL rmid_strobe: got %b want 0", O_STROBE); end
        n_total++; if (O_CMD_READY !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", O_CMD_READY); end
        tick();
        I_RESET = 1'b0;
        tick();
        l = 20'($urandom()); r = 20'($urandom());
        I_SO2 = l; I_SO1 = r;
        run_bits(0, 256);
        e = model_frame(1'b0, 7'd0, 16'd0, l, r);
        n_total++; if (cap_sd[255:240] !== 16'h9800) begin n_bad++; $display("FAIL rmid_tag: got %h want 9800", cap_sd[255:240]); end
        n_total++; if (cap_sd !== e) begin n_bad++; $display("FAIL rmid_frame: got %h want %h", cap_sd, e); end
        n_total++; if (cap_stb !== STB_EXP) begin n_bad++; $display("FAIL rmid_strobe_pos: got %h want %h", cap_stb, STB_EXP); end
        n_total++; if (cap_rdy !== '1) begin n_bad++; $display("FAIL rmid_ready_frame: got %h want all ones", cap_rdy); end
    endtask

    initial begin
        I_RESET     = 1'b1;
        I_BITCLK    = 1'b0;
        I_SO1       = '0;
        I_SO2       = '0;
        I_CMD_VALID = 1'b0;
        I_CMD_ADDR  = '0;
        I_CMD_DATA  = '0;
        test_reset();
        test_basic();
        test_command();
        test_back_to_back();
        test_frame_start_cmd();
        test_so1_change();
        test_stopped();
        test_div9();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
